// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Turns field-level instruction requests (kind, registers, funct3, immediate)
//   into 32-bit RV32I words and streams them into instruction memory at
//   sequential word addresses. The boot/test loader uses it to build programs
//   in IMEM before the core leaves reset. The supported classes match the main
//   opcode decoder: lw, sw, R-type, beq-class branches, I-type ALU and jal.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, base_addr      begin a session (IDLE only); base forced word-aligned
//   req_valid/req_ready   request handshake
//   req_kind              0=LOAD 1=STORE 2=RTYPE 3=BRANCH 4=ITYPE 5=JAL, 6/7 illegal
//   req_last              final request of the session
//   rd, rs1, rs2, funct3, funct7b5, imm   instruction fields (imm in bytes)
//   imem_we/imem_ready    IMEM write handshake
//   imem_addr, imem_wdata IMEM write byte address and encoded word
//   busy                  not IDLE
//   done                  one-cycle pulse when the session has drained
//   word_count            words written in the current/last session
//   err                   sticky error, cleared by start or reset
//
// Configuration macro:
//   IMM_RANGE_CHECK_EN    when defined, err is also raised for immediates that
//                         do not fit their field (the truncated word is still
//                         written).
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic              req_last,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [31:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_count,
  output logic              err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] KIND_LOAD   = 3'd0;
  localparam logic [2:0] KIND_STORE  = 3'd1;
  localparam logic [2:0] KIND_RTYPE  = 3'd2;
  localparam logic [2:0] KIND_BRANCH = 3'd3;
  localparam logic [2:0] KIND_ITYPE  = 3'd4;
  localparam logic [2:0] KIND_JAL    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         word_count_q, word_count_d;
  logic                err_q, err_d;
  logic [31:0]         fifo_mem_q [FIFO_DEPTH];

  logic [31:0]         enc_word;
  logic                kind_legal;
  logic                imm_bad;
  logic                accept;
  logic                push;
  logic                pop;

  // The two low base-address bits are deliberately dropped (word alignment).
  logic                unused_base_lo;
  assign unused_base_lo = ^base_addr[1:0];

  // ---------------------------------------------------------------------------
  // Field encoder: purely combinational on the presented request.
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_word   = '0;
    kind_legal = 1'b1;
    case (req_kind)
      KIND_LOAD:   enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      KIND_STORE:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      KIND_RTYPE:  enc_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
      KIND_BRANCH: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      KIND_ITYPE:  enc_word = {imm[11:0], rs1, funct3, rd, OP_ITYPE};
      KIND_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default:     kind_legal = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate fits if every bit above the field's sign bit equals that sign
  // bit; branch/jump targets must additionally be halfword aligned.
  always_comb begin
    imm_bad = 1'b0;
    case (req_kind)
      KIND_LOAD, KIND_STORE, KIND_ITYPE:
        imm_bad = (imm[31:11] != {21{imm[11]}});
      KIND_BRANCH:
        imm_bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
      KIND_JAL:
        imm_bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
      default:
        imm_bad = 1'b0;
    endcase
  end
`else
  // Without range checking the upper immediate bits are silently truncated.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];
  assign imm_bad       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshakes and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  assign req_ready  = (state_q == ST_LOAD) && (cnt_q < DEPTH_C);
  assign accept     = req_valid && req_ready;
  // Illegal kinds are consumed but never produce a word.
  assign push       = accept && kind_legal;
  assign imem_we    = (cnt_q != '0);
  assign pop        = imem_we && imem_ready;
  // Head is read combinationally so a word accepted at N is visible at N+1.
  assign imem_wdata = imem_we ? fifo_mem_q[rd_ptr_q] : 32'h0;
  assign imem_addr  = ptr_q;
  assign busy       = (state_q != ST_IDLE);
  assign word_count = word_count_q;
  assign err        = err_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    done         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_LOAD;
          ptr_d        = {base_addr[ADDR_W-1:2], 2'b00};
          word_count_d = '0;
          err_d        = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept && req_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept && (!kind_legal || imm_bad)) begin
      err_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    // The FIFO is always empty in IDLE, so a pop never collides with the
    // pointer load on start.
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      ptr_d        = ptr_q + ADDR_W'(4);
      word_count_d = word_count_q + 16'd1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= enc_word;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Table of hand-encoded RV32I vectors applied through the request port;
// every IMEM write is checked against a scoreboard queue of expected
// {address, word} pairs filled when a request is accepted. Hand-written
// sequences cover backpressure, illegal kinds, address wrap and reset
// mid-session.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic              req_last;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [31:0]       imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic [15:0]       word_count;
  logic              err;

  instr_encoder_loader #(
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_last  (req_last),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .imm       (imm),
    .imem_we   (imem_we),
    .imem_ready(imem_ready),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .busy      (busy),
    .done      (done),
    .word_count(word_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t        vecs [13];
  vec_t        ill6;
  vec_t        ill7;
  vec_t        cur;
  wr_t         sb [$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [31:0] exp_addr = 32'h0;
  bit          rnd_ready = 1'b0;

  function automatic vec_t mk(input logic [2:0] kind, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                              input logic [31:0] im, input logic [31:0] ex);
    vec_t v;
    v.kind = kind; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f3;
    v.f7b5 = f7; v.imm = im; v.exp = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic set_req(input vec_t v, input bit last);
    cur       = v;
    req_valid = 1'b1;
    req_kind  = v.kind;
    rd        = v.rd;
    rs1       = v.rs1;
    rs2       = v.rs2;
    funct3    = v.f3;
    funct7b5  = v.f7b5;
    imm       = v.imm;
    req_last  = last;
  endtask

  // One clock: sample at the falling edge (write monitor + accept detection),
  // then step to just after the rising edge where new stimulus is applied.
  task automatic tick(output bit acc);
    wr_t e;
    @(negedge clk);
    if (done) done_cnt++;
    if (imem_we && imem_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        $display("write addr=0x%08h data=0x%08h", imem_addr, imem_wdata);
        check("write_addr", imem_addr, e.addr);
        check("write_data", imem_wdata, e.data);
      end
    end
    acc = req_valid && req_ready;
    if (acc) begin
      $display("accept kind=%0d last=%0d", req_kind, req_last);
      if (cur.kind <= 3'd5) begin
        e.addr = exp_addr;
        e.data = cur.exp;
        sb.push_back(e);
        exp_addr = exp_addr + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (rnd_ready) imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input vec_t v, input bit last);
    bit acc;
    int n;
    n = 0;
    set_req(v, last);
    acc = 1'b0;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: request kind %0d not accepted, expected accept within 200 cycles", v.kind);
    end
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic start_session(input logic [31:0] base);
    bit acc;
    base_addr = base;
    start     = 1'b1;
    tick(acc);
    start     = 1'b0;
    exp_addr  = {base[31:2], 2'b00};
    check("start_busy", 32'(busy), 32'd1);
    check("start_word_count", 32'(word_count), 32'd0);
    check("start_err", 32'(err), 32'd0);
  endtask

  task automatic wait_done();
    bit acc;
    int n;
    n = 0;
    done_cnt = 0;
    while (done_cnt == 0 && n < 300) begin
      tick(acc);
      n++;
    end
    repeat (3) tick(acc);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    bit acc;
    int idx;

    // kind rd rs1 rs2 f3 f7b5 imm expected
    vecs[0]  = mk(3'd0,  5, 2,  0, 3'd2, 1'b0, 32'd8,          32'h00812283); // lw x5,8(x2)
    vecs[1]  = mk(3'd2,  3, 1,  2, 3'd0, 1'b0, 32'd0,          32'h002081B3); // add x3,x1,x2
    vecs[2]  = mk(3'd1,  0, 2,  6, 3'd2, 1'b0, 32'd12,         32'h00612623); // sw x6,12(x2)
    vecs[3]  = mk(3'd5,  1, 0,  0, 3'd0, 1'b0, 32'd16,         32'h010000EF); // jal x1,+16
    vecs[4]  = mk(3'd3,  0, 0,  0, 3'd0, 1'b0, -32'sd4,        32'hFE000EE3); // beq x0,x0,-4
    vecs[5]  = mk(3'd2, 10, 11, 12, 3'd0, 1'b1, 32'd0,         32'h40C58533); // sub a0,a1,a2
    vecs[6]  = mk(3'd4,  1, 0,  0, 3'd0, 1'b0, -32'sd1,        32'hFFF00093); // addi x1,x0,-1
    vecs[7]  = mk(3'd4,  5, 6,  0, 3'd7, 1'b0, 32'h7FF,        32'h7FF37293); // andi x5,x6,2047
    vecs[8]  = mk(3'd0, 31, 31, 0, 3'd2, 1'b0, -32'sd2048,     32'h800FAF83); // lw x31,-2048(x31)
    vecs[9]  = mk(3'd1,  0, 1, 31, 3'd2, 1'b0, -32'sd1,        32'hFFF0AFA3); // sw x31,-1(x1)
    vecs[10] = mk(3'd3,  0, 1,  2, 3'd1, 1'b0, 32'd8,          32'h00209463); // bne x1,x2,+8
    vecs[11] = mk(3'd5,  0, 0,  0, 3'd0, 1'b0, -32'sd8,        32'hFF9FF06F); // jal x0,-8
    vecs[12] = mk(3'd5,  1, 0,  0, 3'd0, 1'b0, 32'd2048,       32'h001000EF); // jal x1,+2048
    ill6     = mk(3'd6,  7, 7,  7, 3'd0, 1'b0, 32'd0,          32'h0);
    ill7     = mk(3'd7,  7, 7,  7, 3'd0, 1'b0, 32'd0,          32'h0);

    reset = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0; req_kind = '0;
    req_last = 1'b0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7b5 = 1'b0;
    imm = '0; imem_ready = 1'b1; cur = ill6;

    // Reset values
    #3;
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_imem_wdata", imem_wdata, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    tick(acc);

    // Single LOAD with last: minimum latency, one write, done, count
    start_session(32'h100);
    send(vecs[0], 1'b1);
    check("latency_we", 32'(imem_we), 32'd1);
    check("latency_addr", imem_addr, 32'h100);
    wait_done();
    check("single_word_count", 32'(word_count), 32'd1);

    // Whole table in one session with random IMEM backpressure
    start_session(32'h1003);
    rnd_ready = 1'b1;
    for (int i = 1; i <= 12; i++) send(vecs[i], i == 12);
    wait_done();
    rnd_ready  = 1'b0;
    imem_ready = 1'b1;
    check("table_word_count", 32'(word_count), 32'd12);
    check("table_err", 32'(err), 32'd0);

    // Stalled IMEM: only FIFO_DEPTH accepts; start while busy is ignored
    imem_ready = 1'b0;
    start_session(32'h200);
    idx = 0;
    set_req(vecs[1], 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick(acc);
      if (acc) begin
        idx++;
        set_req(vecs[idx + 1], 1'b0);
      end
    end
    check("bp_accepts", 32'(idx), 32'(FIFO_DEPTH));
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_imem_we", 32'(imem_we), 32'd1);
    base_addr = 32'h7770;
    start     = 1'b1;
    tick(acc);
    start     = 1'b0;
    imem_ready = 1'b1;
    for (int i = idx + 1; i <= 5; i++) send(vecs[i], i == 5);
    wait_done();
    check("bp_word_count", 32'(word_count), 32'd5);

    // Illegal kind mid-stream: err sticky, address does not advance
    start_session(32'h305);
    send(vecs[6], 1'b0);
    send(ill6, 1'b0);
    check("illegal_err", 32'(err), 32'd1);
    send(vecs[7], 1'b1);
    wait_done();
    check("illegal_err_sticky", 32'(err), 32'd1);
    check("illegal_word_count", 32'(word_count), 32'd2);

    // New start clears err; illegal kind carrying last still ends session
    start_session(32'h400);
    send(ill7, 1'b1);
    wait_done();
    check("illegal_last_count", 32'(word_count), 32'd0);
    check("illegal_last_err", 32'(err), 32'd1);

    // Address pointer wraps modulo 2^ADDR_W
    start_session(32'hFFFF_FFFE);
    send(vecs[11], 1'b0);
    send(vecs[12], 1'b1);
    wait_done();
    check("wrap_ptr", imem_addr, 32'h4);

    // Reset with two words buffered
    imem_ready = 1'b0;
    start_session(32'h500);
    send(vecs[8], 1'b0);
    send(vecs[9], 1'b0);
    check("pre_reset_we", 32'(imem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_we", 32'(imem_we), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_ready", 32'(req_ready), 32'd0);
    check("mid_reset_addr", imem_addr, 32'h0);
    check("mid_reset_wdata", imem_wdata, 32'h0);
    sb.delete();
    tick(acc);
    reset      = 1'b0;
    imem_ready = 1'b1;
    tick(acc);
    start_session(32'h600);
    send(vecs[10], 1'b1);
    wait_done();
    check("post_reset_count", 32'(word_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
